stream_concat_packer: RTL

Parametrised, sequential successor to the fixed three-field concatenation block. It accepts a stream of IN_W-bit fields over a valid/ready handshake and concatenates them MSB-first, as `{first, second, third, ...}` would, into OUT_W-bit output words. Bits spill across word boundaries; none are truncated. A flush request drains any partial word, zero-padded, with a valid-bit count. It sits between field producers and word-wide consumers such as register files or serialisers.

---
 rtl/stream_concat_packer.sv | 96 +++++++++
 1 files changed

// File: rtl/stream_concat_packer.sv
// Packs IN_W-bit fields MSB-first into OUT_W-bit words; flush drains a zero-padded partial word.
// Latency: a word completed by an input fire is presented the following cycle; outputs come from registers only.
// Backpressure: a pending word stalls input (in_ready=0) and holds out_* stable until out_ready.
module stream_concat_packer #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  localparam int ACC_W = OUT_W + IN_W - 1,
  localparam int CNT_W = $clog2(ACC_W + 1),
  localparam int OB_W  = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OB_W-1:0]  out_bits,
  output logic             out_last
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] sh;
  logic             in_fire, out_fire;

  // State and accumulator registers; reset discards all held bits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Handshakes, output word selection and next accumulator/state.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_bits  = '0;
    out_data  = '0;
    sh        = CNT_W'(ACC_W - IN_W) - cnt;

    case (state)
      FILL: begin
        // Accept fields only while a whole word is not yet held, so input and
        // output never fire together here and cnt stays within ACC_W.
        in_ready  = (cnt < CNT_W'(OUT_W));
        out_valid = (cnt >= CNT_W'(OUT_W));
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt <= CNT_W'(OUT_W));
      end
      default: ;
    endcase

    if (out_valid) begin
      out_data = acc[ACC_W-1 -: OUT_W];
      out_bits = out_last ? OB_W'(cnt) : OB_W'(OUT_W);
    end

    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    if (in_fire) begin
      acc_nxt = acc | (ACC_W'(in_data) << sh);
      cnt_nxt = cnt + CNT_W'(IN_W);
    end

    if (out_fire) begin
      // Bits below the held ones are zero, so the last drain shift empties acc.
      acc_nxt = acc << OUT_W;
      cnt_nxt = out_last ? '0 : cnt - CNT_W'(OUT_W);
    end

    if (state == FILL && flush && cnt_nxt != '0)
      state_nxt = DRAIN;
    else if (state == DRAIN && out_fire && out_last)
      state_nxt = FILL;
  end

endmodule
